// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit slice per stage,
// carry and partial sum handed forward stage to stage under a single global advance.
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov,
    output logic             g_out,
    output logic             p_out
);

    localparam int N = WIDTH / BLOCK;

    // Each carry is a flat sum of products: g[j] & p[i:j+1], plus p[i:0] & cin.
    function automatic logic [BLOCK:0] cla_carries(input logic [BLOCK-1:0] g,
                                                   input logic [BLOCK-1:0] p,
                                                   input logic             cin);
        logic [BLOCK:0] c;
        logic           term;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            term = cin;
            for (int j = 0; j <= i; j++) term = term & p[j];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    logic                     advance;

    logic [N-1:0]             vld_q,  vld_d,  vld_in;
    logic [N-1:0]             cy_q,   cy_d,   cy_in;
    logic [N-1:0]             gg_q,   gg_d,   gg_in;
    logic [N-1:0]             pp_q,   pp_d,   pp_in;
    logic [N-1:0][WIDTH-1:0]  sum_q,  sum_d,  sum_in;
    logic [N-1:0][WIDTH-1:0]  a_q,    a_d,    a_in;
    logic [N-1:0][WIDTH-1:0]  b_q,    b_d,    b_in;
    logic                     cm_q,   cm_d;

    // The last stage's skew registers and already-consumed skew bits are never read.
    logic                     unused_skew;
    assign unused_skew = ^{a_q, b_q};

    assign advance  = !vld_q[N-1] | out_ready;
    assign in_ready = advance;

    always_comb begin
        vld_in[0] = in_valid;
        cy_in[0]  = sub | ci;
        gg_in[0]  = 1'b0;
        pp_in[0]  = 1'b1;
        sum_in[0] = '0;
        a_in[0]   = a;
        b_in[0]   = sub ? ~b : b;
        for (int k = 1; k < N; k++) begin
            vld_in[k] = vld_q[k-1];
            cy_in[k]  = cy_q[k-1];
            gg_in[k]  = gg_q[k-1];
            pp_in[k]  = pp_q[k-1];
            sum_in[k] = sum_q[k-1];
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
        end
    end

    always_comb begin
        logic [BLOCK-1:0] sa;
        logic [BLOCK-1:0] sb;
        logic [BLOCK-1:0] sg;
        logic [BLOCK-1:0] sp;
        logic [BLOCK:0]   sc;
        logic [BLOCK:0]   gc;
        logic [WIDTH-1:0] keep;
        sa    = '0;
        sb    = '0;
        sg    = '0;
        sp    = '0;
        sc    = '0;
        gc    = '0;
        keep  = '0;
        vld_d = '0;
        cy_d  = '0;
        gg_d  = '0;
        pp_d  = '0;
        sum_d = '0;
        a_d   = '0;
        b_d   = '0;
        cm_d  = 1'b0;
        for (int k = 0; k < N; k++) begin
            sa   = a_in[k][k*BLOCK +: BLOCK];
            sb   = b_in[k][k*BLOCK +: BLOCK];
            sg   = sa & sb;
            sp   = sa | sb;
            sc   = cla_carries(sg, sp, cy_in[k]);
            gc   = cla_carries(sg, sp, 1'b0);
            keep = {WIDTH{1'b1}} << ((k + 1) * BLOCK);

            vld_d[k]                   = vld_in[k];
            cy_d[k]                    = sc[BLOCK];
            sum_d[k]                   = sum_in[k];
            sum_d[k][k*BLOCK +: BLOCK] = sa ^ sb ^ sc[BLOCK-1:0];
            gg_d[k]                    = gc[BLOCK] | ((&sp) & gg_in[k]);
            pp_d[k]                    = pp_in[k] & (&sp);
            a_d[k]                     = a_in[k] & keep;
            b_d[k]                     = b_in[k] & keep;
            if (k == N - 1) cm_d = sc[BLOCK-1];
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            vld_q <= '0;
            cy_q  <= '0;
            gg_q  <= '0;
            pp_q  <= '0;
            sum_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cm_q  <= 1'b0;
        end else if (advance) begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            gg_q  <= gg_d;
            pp_q  <= pp_d;
            sum_q <= sum_d;
            a_q   <= a_d;
            b_q   <= b_d;
            cm_q  <= cm_d;
        end
    end

    assign out_valid = vld_q[N-1];
    assign s         = sum_q[N-1];
    assign co        = cy_q[N-1];
    assign ov        = cm_q ^ cy_q[N-1];
    assign g_out     = gg_q[N-1];
    assign p_out     = pp_q[N-1];

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed vectors, backpressure, mid-flight reset,
// and random streams on the single-stage and 16/4 configurations.
module tb_pipelined_cla_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic clrn;

    logic        iv0, ir0, sub0, ci0, ovld0, ordy0, co0, ovf0, g0, p0;
    logic [31:0] a0, b0, s0;
    logic        iv1, ir1, sub1, ci1, ovld1, ordy1, co1, ovf1, g1, p1;
    logic [31:0] a1, b1, s1;
    logic        iv2, ir2, sub2, ci2, ovld2, ordy2, co2, ovf2, g2, p2;
    logic [15:0] a2, b2, s2;

    pipelined_cla_adder #(.WIDTH(32), .BLOCK(8)) u_dut0 (
        .clk(clk), .clrn(clrn), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .sub(sub0), .ci(ci0), .out_valid(ovld0), .out_ready(ordy0), .s(s0),
        .co(co0), .ov(ovf0), .g_out(g0), .p_out(p0));

    pipelined_cla_adder #(.WIDTH(32), .BLOCK(32)) u_dut1 (
        .clk(clk), .clrn(clrn), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .sub(sub1), .ci(ci1), .out_valid(ovld1), .out_ready(ordy1), .s(s1),
        .co(co1), .ov(ovf1), .g_out(g1), .p_out(p1));

    pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) u_dut2 (
        .clk(clk), .clrn(clrn), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .sub(sub2), .ci(ci2), .out_valid(ovld2), .out_ready(ordy2), .s(s2),
        .co(co2), .ov(ovf2), .g_out(g2), .p_out(p2));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        ci;
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        g;
        logic        p;
    } vec_t;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        g;
        logic        p;
    } res_t;

    int n_chk  = 0;
    int n_fail = 0;
    localparam int NOPS = 10000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic ci, input int w);
        res_t        r;
        logic [31:0] mask, bp;
        logic [32:0] full, nocin;
        mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        bp    = (sub ? ~b : b) & mask;
        full  = {1'b0, a & mask} + {1'b0, bp} + {32'h0, (sub ? 1'b1 : ci)};
        nocin = {1'b0, a & mask} + {1'b0, bp};
        r.s   = full[31:0] & mask;
        r.co  = full[w];
        r.g   = nocin[w];
        r.p   = (((a | bp) & mask) == mask);
        r.ov  = (a[w-1] == bp[w-1]) && (r.s[w-1] != a[w-1]);
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int cnt;
        a0 = v.a; b0 = v.b; sub0 = v.sub; ci0 = v.ci; iv0 = 1'b1; ordy0 = 1'b1;
        cnt = 0;
        while (cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
            iv0 = 1'b0;
            if (ovld0) break;
        end
        check({tag, "_latency"}, cnt, 4);
        check({tag, "_s"},  s0,   v.s);
        check({tag, "_co"}, co0,  v.co);
        check({tag, "_ov"}, ovf0, v.ov);
        check({tag, "_g"},  g0,   v.g);
        check({tag, "_p"},  p0,   v.p);
        @(posedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [10];
        logic [31:0] bp_a [6];
        logic [31:0] bp_b [6];
        logic        bp_sub [6];
        logic        bp_ci [6];
        res_t        e;
        res_t        q1 [$];
        res_t        q2 [$];
        logic [31:0] hs;
        int          sent, rcv, seen;

        vt[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[7] = '{32'h1234_5678, 32'h0FED_CBA8, 1'b0, 1'b0, 32'h2222_2220, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[9] = '{32'hFFFF_FF00, 32'h0000_00FF, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1};

        bp_a = '{32'h1, 32'hFFFF_FFFF, 32'd10, 32'h7FFF_FFFF, 32'h0001_0000, 32'hDEAD_BEEF};
        bp_b = '{32'h2, 32'h1,         32'd3,  32'h7FFF_FFFF, 32'h0002_0000, 32'h1234_5678};
        bp_sub = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bp_ci  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        clrn = 1'b0;
        iv0 = 0; a0 = '0; b0 = '0; sub0 = 0; ci0 = 0; ordy0 = 1;
        iv1 = 0; a1 = '0; b1 = '0; sub1 = 0; ci1 = 0; ordy1 = 1;
        iv2 = 0; a2 = '0; b2 = '0; sub2 = 0; ci2 = 0; ordy2 = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", ovld0, 0);
        check("reset_in_ready",  ir0,   1);
        check("reset_outputs",   {s0, co0, ovf0, g0, p0}, 0);
        check("reset_out_valid1", ovld1, 0);
        check("reset_out_valid2", ovld2, 0);
        clrn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Six back-to-back ops with the consumer stalled for cycles 5..7.
        sent = 0; rcv = 0; hs = '0;
        for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
            ordy0 = !(cyc >= 5 && cyc <= 7);
            iv0   = (sent < 6);
            if (sent < 6) begin
                a0 = bp_a[sent]; b0 = bp_b[sent]; sub0 = bp_sub[sent]; ci0 = bp_ci[sent];
            end
            #4;
            if (!ordy0) begin
                check("bp_in_ready_low", ir0, 0);
                check("bp_out_valid_held", ovld0, 1);
                if (cyc == 5) hs = s0;
                else check("bp_hold_s", s0, hs);
            end
            if (ovld0 && ordy0) begin
                e = model(bp_a[rcv], bp_b[rcv], bp_sub[rcv], bp_ci[rcv], 32);
                check($sformatf("bp_res%0d", rcv), {s0, co0, ovf0, g0, p0},
                      {e.s, e.co, e.ov, e.g, e.p});
                rcv++;
            end
            if (iv0 && ir0) sent++;
            @(posedge clk); #1;
        end
        check("bp_result_count", rcv, 6);
        iv0 = 1'b0; ordy0 = 1'b1;

        // Fill the pipeline with out_ready low, then reset with a result on the output.
        ordy0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iv0 = 1'b1; a0 = vt[5 + i].a; b0 = vt[5 + i].b; sub0 = vt[5 + i].sub; ci0 = vt[5 + i].ci;
            @(posedge clk); #1;
        end
        iv0 = 1'b0;
        check("rst_pre_valid", ovld0, 1);
        check("rst_pre_result", {s0, co0, ovf0, g0, p0}, {vt[5].s, vt[5].co, vt[5].ov, vt[5].g, vt[5].p});
        #1 clrn = 1'b0;
        #1;
        check("rst_async_valid", ovld0, 0);
        check("rst_async_outputs", {s0, co0, ovf0, g0, p0}, 0);
        check("rst_async_in_ready", ir0, 1);
        @(posedge clk); #1;
        clrn = 1'b1; ordy0 = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ovld0) seen = 1;
        end
        check("rst_no_stale_result", seen, 0);
        run_vec(vt[3], "post_reset");

        // Random streams on the single-stage and 16/4 configurations.
        begin
            int   sent1, sent2, rcv1, rcv2, cyc;
            logic held1, held2;
            logic [35:0] h1;
            logic [19:0] h2;
            sent1 = 0; sent2 = 0; rcv1 = 0; rcv2 = 0; cyc = 0;
            held1 = 1'b0; held2 = 1'b0; h1 = '0; h2 = '0;
            while ((rcv1 < NOPS || rcv2 < NOPS) && cyc < 60000) begin
                iv1 = (sent1 < NOPS) && ($urandom_range(0, 3) != 0);
                a1 = $urandom; b1 = $urandom;
                sub1 = 1'($urandom_range(0, 1)); ci1 = 1'($urandom_range(0, 1));
                ordy1 = ($urandom_range(0, 3) != 0);
                iv2 = (sent2 < NOPS) && ($urandom_range(0, 3) != 0);
                a2 = 16'($urandom); b2 = 16'($urandom);
                sub2 = 1'($urandom_range(0, 1)); ci2 = 1'($urandom_range(0, 1));
                ordy2 = ($urandom_range(0, 3) != 0);
                #4;
                check("sw1_in_ready", ir1, !ovld1 || ordy1);
                if (held1) check("sw1_hold", {ovld1, s1, co1, ovf1, g1, p1}, {1'b1, h1});
                held1 = ovld1 && !ordy1;
                h1 = {s1, co1, ovf1, g1, p1};
                if (ovld1 && ordy1) begin
                    if (q1.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL sw1_spurious: got out_valid=1, expected no pending result");
                    end else begin
                        e = q1.pop_front();
                        check("sw1_res", {s1, co1, ovf1, g1, p1}, {e.s, e.co, e.ov, e.g, e.p});
                    end
                    rcv1++;
                end
                if (iv1 && ir1) begin q1.push_back(model(a1, b1, sub1, ci1, 32)); sent1++; end

                check("sw2_in_ready", ir2, !ovld2 || ordy2);
                if (held2) check("sw2_hold", {ovld2, s2, co2, ovf2, g2, p2}, {1'b1, h2});
                held2 = ovld2 && !ordy2;
                h2 = {s2, co2, ovf2, g2, p2};
                if (ovld2 && ordy2) begin
                    if (q2.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL sw2_spurious: got out_valid=1, expected no pending result");
                    end else begin
                        e = q2.pop_front();
                        check("sw2_res", {s2, co2, ovf2, g2, p2}, {e.s[15:0], e.co, e.ov, e.g, e.p});
                    end
                    rcv2++;
                end
                if (iv2 && ir2) begin q2.push_back(model({16'h0, a2}, {16'h0, b2}, sub2, ci2, 16)); sent2++; end
                @(posedge clk); #1;
                cyc++;
            end
            check("sw1_result_count", rcv1, NOPS);
            check("sw2_result_count", rcv2, NOPS);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the integer and FPU mantissa datapaths.
- Operand width is split into BLOCK-bit slices; each pipeline stage resolves one slice with bit-level generate/propagate lookahead and registers the carry into the next stage.
- Valid/ready handshakes on input and output give a throughput of one operation per cycle and a full-pipeline stall under backpressure.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of BLOCK.
- BLOCK, 8, bits resolved per pipeline stage. Number of stages N = WIDTH/BLOCK; BLOCK = WIDTH gives a single stage.

Ports:
- clk  in  1  clock, rising-edge.
- clrn  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  1 = compute a - b; 0 = compute a + b + ci.
- ci  in  1  carry-in; ignored when sub = 1.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer accepts the result.
- s  out  WIDTH  sum or difference, modulo 2^WIDTH.
- co  out  1  carry out of bit WIDTH-1. For subtract, 1 means no borrow.
- ov  out  1  signed overflow, equal to (carry into MSB) ^ co.
- g_out  out  1  word-level generate of (a, b'), evaluated with carry-in forced to 0.
- p_out  out  1  word-level propagate, equal to AND over all bits of (a[i] | b'[i]).

Behaviour:
- Effective operand b' = sub ? ~b : b. Effective carry-in c0 = sub ? 1 : ci.
- Per bit: g = a & b', p = a | b', s = a ^ b' ^ c. Carry within a slice: c[i+1] = g[i] | (p[i] & c[i]), expressed as lookahead terms inside the slice.
- Stage k (0..N-1) computes slice bits [k*BLOCK +: BLOCK] from its registered incoming carry.
- Each stage registers:
  - its valid bit and outgoing carry;
  - the sum bits completed so far;
  - the operand bits not yet consumed (skew registers);
  - the running group g/p and the carry into the MSB.
- Latency: N cycles from input acceptance to out_valid, with no stall.
- advance = !out_valid | out_ready. All stage registers load only when advance = 1. When advance = 0, every stage holds, including its valid bits.
- in_ready = advance, which is combinational from out_valid and out_ready. An input transfer occurs when in_valid & in_ready.
- When advance = 1 and in_valid = 0, a bubble enters stage 0 with valid = 0. Bubbles propagate, and their data fields are don't-care.
- Hold rule: while out_valid = 1 and out_ready = 0, the outputs s, co, ov, g_out and p_out stay stable.
- Back-to-back inputs with out_ready held at 1 give one result per cycle, in order, with none dropped or duplicated.
- Reset: clrn low asynchronously clears every valid bit and every data register. The result is out_valid = 0 and s, co, ov, g_out, p_out = 0, with in_ready = 1 once out_valid = 0. Reset mid-operation discards all in-flight operations, and no stale result appears after clrn rises.
- Wrap-around: the sum is truncated to WIDTH bits. co and ov report the carry and overflow conditions as defined above.
- N = 1 case: a single register stage, latency 1, with the same handshake.
- Simultaneous events: an output accept (out_ready = 1) and an input accept in the same cycle is legal. The pipeline shifts by one and the new result enters the output stage.

Test Plan:
- Add, WIDTH = 32, BLOCK = 8: a = 0x0000_00FF, b = 0x0000_0001, sub = 0, ci = 0 -> after 4 cycles out_valid = 1, s = 0x0000_0100, co = 0, ov = 0, g_out = 0, p_out = 0. This checks carry crossing a slice boundary.
- Full carry chain: a = 0xFFFF_FFFF, b = 0, ci = 1 -> s = 0, co = 1, ov = 0, p_out = 1, g_out = 0.
- Signed overflow and subtract:
  - a = 0x7FFF_FFFF, b = 1, add -> s = 0x8000_0000, ov = 1, co = 0.
  - a = 5, b = 7, sub = 1 -> s = 0xFFFF_FFFE, co = 0 (borrow), ov = 0.
- Backpressure: stream 6 operations back-to-back, holding out_ready = 0 for 3 cycles mid-stream:
  - in_ready drops in those cycles;
  - s stays stable while held;
  - all 6 results emerge in order, matching a reference model.
- Reset mid-flight: issue 3 operations, pull clrn low for 1 cycle on cycle 2 -> out_valid = 0 immediately and all outputs read 0. No result ever appears for those 3 operations, and a new op issued after reset completes correctly at latency 4.
- Parameter sweep: with BLOCK = 32 and WIDTH = 32 (latency 1), and with WIDTH = 16, BLOCK = 4 (latency 4), run 10k random operations with random in_valid and out_ready -> no mismatch against the behavioural a + b' + c0 model.
